// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-memory loads/stores, formats store
// lanes, extends load data and registers results into the MEM/WB register.
module mem_access_stage #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [ADDR_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic                  i_mem_we,
  input  logic                  i_load_instr,
  input  logic [2:0]            i_func3,
  input  logic                  i_reg_we,
  input  logic [2:0]            i_result_src,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
  input  logic [ADDR_WIDTH-1:0] i_pc_target,
  input  logic [DATA_WIDTH-1:0] i_imm_ext,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [7:0]            o_mem_wstrb,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_stall,
  output logic                  o_misaligned,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic [ADDR_WIDTH-1:0] o_alu_result,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic [ADDR_WIDTH-1:0] o_pc_target,
  output logic [DATA_WIDTH-1:0] o_imm_ext,
  output logic [2:0]            o_result_src,
  output logic                  o_reg_we,
  output logic [REG_ADDR_W-1:0] o_rd_addr
);

  localparam int unsigned OFF_W  = 3;
  localparam int unsigned STRB_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_RSP = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [OFF_W-1:0]      off;
  logic                  mem_op, is_store, is_load;
  logic                  align_err, illegal, mis_c;
  logic                  req_valid_c, done_c, stall_c;
  logic [STRB_W-1:0]     strb_base;
  logic [DATA_WIDTH-1:0] load_word, load_ext;

  logic [ADDR_WIDTH-1:0] alu_q, pc4_q, pct_q;
  logic [DATA_WIDTH-1:0] imm_q, rdata_q;
  logic [2:0]            rsrc_q;
  logic                  reg_we_q, mis_q;
  logic [REG_ADDR_W-1:0] rd_q;

  assign off      = i_alu_result[OFF_W-1:0];
  assign mem_op   = i_load_instr | i_mem_we;
  assign is_store = i_mem_we;
  assign is_load  = i_load_instr & ~i_mem_we;

  // Alignment and illegal-encoding detection for the current access
  always_comb begin
    align_err = 1'b0;
    case (i_func3[1:0])
      2'd0:    align_err = 1'b0;
      2'd1:    align_err = off[0];
      2'd2:    align_err = |off[1:0];
      default: align_err = |off;
    endcase
    illegal = (is_load & (i_func3 == 3'd7)) | (is_store & i_func3[2]);
    mis_c   = mem_op & (align_err | illegal);
  end

  // Store data lane shift and byte strobes; zero when not storing
  always_comb begin
    strb_base   = 8'h00;
    o_mem_wdata = '0;
    o_mem_wstrb = 8'h00;
    case (i_func3[1:0])
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
    if (is_store) begin
      o_mem_wdata = i_write_data << {off, 3'b000};
      o_mem_wstrb = strb_base << off;
    end
  end

  // Load byte-lane extraction with sign/zero extension
  always_comb begin
    load_ext  = '0;
    load_word = i_mem_rdata >> {off, 3'b000};
    case (i_func3)
      3'd0:    load_ext = {{(DATA_WIDTH-8){load_word[7]}},   load_word[7:0]};
      3'd1:    load_ext = {{(DATA_WIDTH-16){load_word[15]}}, load_word[15:0]};
      3'd2:    load_ext = {{(DATA_WIDTH-32){load_word[31]}}, load_word[31:0]};
      3'd3:    load_ext = load_word;
      3'd4:    load_ext = {{(DATA_WIDTH-8){1'b0}},  load_word[7:0]};
      3'd5:    load_ext = {{(DATA_WIDTH-16){1'b0}}, load_word[15:0]};
      3'd6:    load_ext = {{(DATA_WIDTH-32){1'b0}}, load_word[31:0]};
      default: load_ext = '0;
    endcase
  end

  // Request/response FSM: next state, request valid and completion
  always_comb begin
    state_d     = state_q;
    req_valid_c = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !mis_c) begin
          req_valid_c = 1'b1;
          if (i_mem_req_ready) begin
            if (is_store) done_c  = 1'b1;
            else          state_d = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (i_mem_rsp_valid) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall_c = mem_op & ~mis_c & ~done_c;

  // FSM state and MEM/WB pipeline register; bubbles inserted while stalled
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q  <= ST_IDLE;
      alu_q    <= '0;
      pc4_q    <= '0;
      pct_q    <= '0;
      imm_q    <= '0;
      rsrc_q   <= '0;
      reg_we_q <= 1'b0;
      rd_q     <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mis_q   <= mis_c;
      if (!stall_c) begin
        alu_q    <= i_alu_result;
        pc4_q    <= i_pc_plus4;
        pct_q    <= i_pc_target;
        imm_q    <= i_imm_ext;
        rsrc_q   <= i_result_src;
        reg_we_q <= i_reg_we & ~mis_c;
        rd_q     <= i_rd_addr;
        rdata_q  <= (is_load && !mis_c) ? load_ext : '0;
      end else begin
        reg_we_q <= 1'b0;
      end
    end
  end

  assign o_mem_req_valid = req_valid_c;
  assign o_mem_addr      = i_alu_result;
  assign o_mem_we        = i_mem_we;
  assign o_stall         = stall_c;
  assign o_misaligned    = mis_q;
  assign o_read_data     = rdata_q;
  assign o_alu_result    = alu_q;
  assign o_pc_plus4      = pc4_q;
  assign o_pc_target     = pct_q;
  assign o_imm_ext       = imm_q;
  assign o_result_src    = rsrc_q;
  assign o_reg_we        = reg_we_q;
  assign o_rd_addr       = rd_q;

endmodule
